// File: rtl/dom_rand_pkg.sv
// Shared constants and state encoding for the DOM randomness source.
// No logic. No handshake.
package dom_rand_pkg;

    localparam int          LFSR_WIDTH = 32;
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] SAFE_SEED  = 32'h0000_0001;

    typedef enum logic [2:0] {
        UNSEEDED = 3'd0,
        WARMUP   = 3'd1,
        PRIME    = 3'd2,
        RUN      = 3'd3,
        ERROR    = 3'd4
    } state_e;

endpackage

// File: rtl/dom_rand_source_lfsr_unroll.sv
// Unrolls STEPS Fibonacci LFSR steps: feedback bits form the word, bit 0 first.
// Purely combinational, zero latency.
// No handshake; the caller decides when to register the result.
module lfsr_unroll
    import dom_rand_pkg::*;
#(
    parameter int STEPS = 1
) (
    input  logic [LFSR_WIDTH-1:0] s,
    output logic [STEPS-1:0]      word,
    output logic [LFSR_WIDTH-1:0] s_next
);

    logic [LFSR_WIDTH-1:0] t;

    always_comb begin
        t    = s;
        word = '0;
        for (int i = 0; i < STEPS; i++) begin
            word[i] = ^(t & LFSR_TAPS);
            t       = {t[LFSR_WIDTH-2:0], word[i]};
        end
        s_next = t;
    end

endmodule

// File: rtl/dom_rand_source.sv
// Seeded 32-bit LFSR delivering RAND_WIDTH fresh bits per handshake to DOM gadgets.
// First word valid WARMUP_STEPS+2 cycles after seed accept; rand_o is registered.
// rand_o and the LFSR hold while rand_ready is low; seed_ready drops only on fault.
module dom_rand_source
    import dom_rand_pkg::*;
#(
    parameter int RAND_WIDTH   = 1,
    parameter int WARMUP_STEPS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seed_valid,
    input  logic [31:0]           seed_data,
    output logic                  seed_ready,
    output logic [RAND_WIDTH-1:0] rand_o,
    output logic                  rand_valid,
    input  logic                  rand_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int CW = (WARMUP_STEPS > 0) ? $clog2(WARMUP_STEPS + 1) : 1;
    localparam state_e LOAD_TARGET = (WARMUP_STEPS == 0) ? PRIME : WARMUP;

    state_e                  state_q, state_d;
    logic [LFSR_WIDTH-1:0]   lfsr_q;
    logic [RAND_WIDTH-1:0]   rand_q;
    logic [CW-1:0]           cnt_q;

    logic [LFSR_WIDTH-1:0]   seed_fix;
    logic [LFSR_WIDTH-1:0]   warm_next;
    logic                    warm_fb;
    logic [RAND_WIDTH-1:0]   gen_word;
    logic [LFSR_WIDTH-1:0]   gen_next;
    logic                    fault;
    logic                    unused_warm_fb;

    lfsr_unroll #(.STEPS(1)) u_warm (
        .s      (lfsr_q),
        .word   (warm_fb),
        .s_next (warm_next)
    );

    lfsr_unroll #(.STEPS(RAND_WIDTH)) u_gen (
        .s      (lfsr_q),
        .word   (gen_word),
        .s_next (gen_next)
    );

    // Warm-up only needs the advanced state, the discarded bit is dropped here.
    assign unused_warm_fb = warm_fb;

    assign seed_fix = (seed_data == '0) ? SAFE_SEED : seed_data;
    assign fault    = (state_q != UNSEEDED) && (lfsr_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNSEEDED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNSEEDED: if (seed_valid) state_d = LOAD_TARGET;
            ERROR:    state_d = ERROR;
            default: begin
                if (fault) begin
                    state_d = ERROR;
                end else if (seed_valid) begin
                    state_d = LOAD_TARGET;
                end else begin
                    case (state_q)
                        WARMUP:  if (cnt_q <= CW'(1)) state_d = PRIME;
                        PRIME:   state_d = RUN;
                        default: state_d = state_q;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        rand_valid = (state_q == RUN);
        busy       = (state_q == WARMUP) || (state_q == PRIME);
        err        = (state_q == ERROR);
        seed_ready = (state_q != ERROR);
    end

    // Fault outranks reseed, reseed outranks the consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
            rand_q <= '0;
            cnt_q  <= '0;
        end else if (state_q == UNSEEDED) begin
            if (seed_valid) begin
                lfsr_q <= seed_fix;
                cnt_q  <= CW'(WARMUP_STEPS);
            end
        end else if (state_q == ERROR || fault) begin
            rand_q <= '0;
        end else if (seed_valid) begin
            lfsr_q <= seed_fix;
            cnt_q  <= CW'(WARMUP_STEPS);
        end else begin
            case (state_q)
                WARMUP: begin
                    lfsr_q <= warm_next;
                    cnt_q  <= cnt_q - CW'(1);
                end
                PRIME: begin
                    rand_q <= gen_word;
                    lfsr_q <= gen_next;
                end
                RUN: begin
                    if (rand_ready) begin
                        rand_q <= gen_word;
                        lfsr_q <= gen_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rand_o = rand_q;

endmodule
